// File: rtl/sseg_scan_decoder.sv
// Receive side of the multiplexed 7-segment bus. It samples the scanned anode and segment lines,
// decodes each settled digit back to BCD and publishes complete 4-digit frames with a valid strobe.
module sseg_scan_decoder #(
  parameter int unsigned SETTLE = 4,
  parameter int unsigned STALE  = 1_000_000
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [3:0] an,
  input  logic [6:0] sseg,
  input  logic       dp,
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic [3:0] dp_map,
  output logic       frame_valid,
  output logic       seg_err,
  output logic       stale
);

  localparam int unsigned SW = $clog2(SETTLE + 1);
  localparam int unsigned IW = $clog2(STALE + 1);

  typedef enum logic {TRACK, HELD} state_t;

  state_t          state, state_nxt;
  logic [3:0]      an_m, an_s;
  logic [6:0]      sseg_m, sseg_s;
  logic            dp_m, dp_s;
  logic [11:0]     s, s_prev;
  logic            same;
  logic [SW-1:0]   stab_cnt, stab_nxt;
  logic [IW-1:0]   idle_cnt, idle_nxt;
  logic [3:0][3:0] slot, slot_nxt;
  logic [3:0]      slot_dp, slot_dp_nxt;
  logic [3:0]      mask, mask_nxt;
  logic            an_valid;
  logic [1:0]      an_idx;
  logic            capture;
  logic            frame_done;
  logic [3:0]      code;

  function automatic logic [3:0] seg_decode(input logic [6:0] p);
    case (p)
      7'b1000000: seg_decode = 4'h0;
      7'b1111001: seg_decode = 4'h1;
      7'b0100100: seg_decode = 4'h2;
      7'b0110000: seg_decode = 4'h3;
      7'b0011001: seg_decode = 4'h4;
      7'b0010010: seg_decode = 4'h5;
      7'b0000010: seg_decode = 4'h6;
      7'b1111000: seg_decode = 4'h7;
      7'b0000000: seg_decode = 4'h8;
      7'b0010000: seg_decode = 4'h9;
      7'b1111111: seg_decode = 4'hB;
      default:    seg_decode = 4'hE;
    endcase
  endfunction

  // Two-flop synchronizers plus the previous-sample register; idle level is all ones.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      an_m   <= 4'hF;
      an_s   <= 4'hF;
      sseg_m <= 7'h7F;
      sseg_s <= 7'h7F;
      dp_m   <= 1'b1;
      dp_s   <= 1'b1;
      s_prev <= 12'hFFF;
    end else begin
      an_m   <= an;
      an_s   <= an_m;
      sseg_m <= sseg;
      sseg_s <= sseg_m;
      dp_m   <= dp;
      dp_s   <= dp_m;
      s_prev <= s;
    end
  end

  assign s    = {an_s, sseg_s, dp_s};
  assign same = (s == s_prev);
  assign code = seg_decode(sseg_s);

  // Exactly one anode low selects a slot; anything else is a gap in the scan.
  always_comb begin
    an_valid = 1'b1;
    an_idx   = 2'd0;
    case (an_s)
      4'b1110: an_idx = 2'd0;
      4'b1101: an_idx = 2'd1;
      4'b1011: an_idx = 2'd2;
      4'b0111: an_idx = 2'd3;
      default: an_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    if (!an_valid) begin
      state_nxt = TRACK;
    end else begin
      case (state)
        TRACK: if (same && (stab_cnt == SW'(SETTLE - 1))) begin
          capture   = 1'b1;
          state_nxt = HELD;
        end
        HELD: if (!same) state_nxt = TRACK;
        default: state_nxt = TRACK;
      endcase
    end
  end

  // Slot/mask update; a frame completing this cycle sees the slot written this cycle.
  always_comb begin
    slot_nxt    = slot;
    slot_dp_nxt = slot_dp;
    mask_nxt    = mask;
    frame_done  = (mask == 4'b1111);
    if (capture) begin
      slot_nxt[an_idx]    = code;
      slot_dp_nxt[an_idx] = ~dp_s;
      mask_nxt[an_idx]    = 1'b1;
    end
    if (frame_done) mask_nxt = capture ? (4'b0001 << an_idx) : 4'b0000;

    if (!same)                      stab_nxt = '0;
    else if (stab_cnt < SW'(SETTLE)) stab_nxt = stab_cnt + SW'(1);
    else                            stab_nxt = stab_cnt;

    if (capture)                    idle_nxt = '0;
    else if (idle_cnt == IW'(STALE)) idle_nxt = idle_cnt;
    else                            idle_nxt = idle_cnt + IW'(1);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state       <= TRACK;
      stab_cnt    <= '0;
      idle_cnt    <= '0;
      slot        <= '0;
      slot_dp     <= '0;
      mask        <= '0;
      d3          <= 4'h0;
      d2          <= 4'h0;
      d1          <= 4'h0;
      d0          <= 4'h0;
      dp_map      <= 4'h0;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      stale       <= 1'b0;
    end else begin
      state       <= state_nxt;
      stab_cnt    <= stab_nxt;
      idle_cnt    <= idle_nxt;
      slot        <= slot_nxt;
      slot_dp     <= slot_dp_nxt;
      mask        <= mask_nxt;
      frame_valid <= frame_done;
      seg_err     <= capture && (code == 4'hE);
      stale       <= (idle_nxt == IW'(STALE));
      if (frame_done) begin
        d3     <= slot_nxt[3];
        d2     <= slot_nxt[2];
        d1     <= slot_nxt[1];
        d0     <= slot_nxt[0];
        dp_map <= slot_dp_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder: expected frames are queued as digits are scanned
// and compared against frames captured from the frame_valid strobe.
module tb_sseg_scan_decoder;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned STALE  = 100;
  localparam int DWELL = 16;

  logic       clk;
  logic       clr_n;
  logic [3:0] an;
  logic [6:0] sseg;
  logic       dp;
  logic [3:0] d3, d2, d1, d0, dp_map;
  logic       frame_valid, seg_err, stale;

  sseg_scan_decoder #(.SETTLE(SETTLE), .STALE(STALE)) dut (
    .clk(clk), .clr_n(clr_n), .an(an), .sseg(sseg), .dp(dp),
    .d3(d3), .d2(d2), .d1(d1), .d0(d0), .dp_map(dp_map),
    .frame_valid(frame_valid), .seg_err(seg_err), .stale(stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cmps = 0;
  int errs = 0;
  int frame_cnt = 0;
  int seg_err_cnt = 0;
  int exp_frames = 0;
  logic [19:0] exp_q[$];
  logic [19:0] obs_q[$];

  // Observe output strobes away from the active edge.
  always @(negedge clk) begin
    if (frame_valid) begin
      obs_q.push_back({d3, d2, d1, d0, dp_map});
      frame_cnt++;
    end
    if (seg_err) seg_err_cnt++;
  end

  function automatic logic [6:0] enc(input int v);
    case (v)
      0: enc = 7'b1000000;
      1: enc = 7'b1111001;
      2: enc = 7'b0100100;
      3: enc = 7'b0110000;
      4: enc = 7'b0011001;
      5: enc = 7'b0010010;
      6: enc = 7'b0000010;
      7: enc = 7'b1111000;
      8: enc = 7'b0000000;
      9: enc = 7'b0010000;
      default: enc = 7'b1111111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_raw(input int idx, input logic [6:0] pat, input logic dp_on);
    logic [3:0] a;
    a = 4'b1111;
    a[idx] = 1'b0;
    an   = a;
    sseg = pat;
    dp   = ~dp_on;
  endtask

  task automatic scan(input int idx, input int val, input logic dp_on);
    drive_raw(idx, enc(val), dp_on);
    step(DWELL);
  endtask

  task automatic expect_frame(input logic [3:0] e3, input logic [3:0] e2, input logic [3:0] e1,
                              input logic [3:0] e0, input logic [3:0] edp);
    exp_q.push_back({e3, e2, e1, e0, edp});
    exp_frames++;
  endtask

  task automatic drain(input string tag);
    while (obs_q.size() > 0 && exp_q.size() > 0) check(tag, obs_q.pop_front(), exp_q.pop_front());
    check({tag, "_missing"}, exp_q.size(), 0);
    check({tag, "_extra"}, obs_q.size(), 0);
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic scan_frame(input string tag, input int v3, input int v2, input int v1,
                            input int v0, input logic [3:0] dpm);
    expect_frame(v3[3:0], v2[3:0], v1[3:0], v0[3:0], dpm);
    scan(3, v3, dpm[3]);
    scan(2, v2, dpm[2]);
    scan(1, v1, dpm[1]);
    scan(0, v0, dpm[0]);
    drain(tag);
  endtask

  initial begin
    clr_n = 1'b0;
    an    = 4'hF;
    sseg  = 7'h7F;
    dp    = 1'b1;
    step(3);
    check("rst_digits", {d3, d2, d1, d0, dp_map}, 20'h0);
    check("rst_valid", frame_valid, 1'b0);
    check("rst_seg_err", seg_err, 1'b0);
    check("rst_stale", stale, 1'b0);
    clr_n = 1'b1;
    step(4);

    scan_frame("t1_1234", 1, 2, 3, 4, 4'b0000);
    check("t1_frames", frame_cnt, exp_frames);

    scan_frame("t2_0958_a", 0, 9, 5, 8, 4'b0100);
    scan_frame("t2_0958_b", 0, 9, 5, 8, 4'b0100);
    check("t2_frames", frame_cnt, exp_frames);

    // Short glitch inside the d1 dwell must neither change the digit nor add a frame.
    expect_frame(4'h7, 4'h6, 4'h1, 4'h0, 4'b0000);
    scan(3, 7, 1'b0);
    scan(2, 6, 1'b0);
    drive_raw(1, enc(1), 1'b0);
    step(8);
    sseg = 7'b0000000;
    step(2);
    sseg = enc(1);
    step(8);
    scan(0, 0, 1'b0);
    drain("t3_glitch");
    check("t3_frames", frame_cnt, exp_frames);
    check("t3_no_seg_err", seg_err_cnt, 0);

    // Blank digit, then an illegal pattern on d0.
    expect_frame(4'hB, 4'h3, 4'h7, 4'hE, 4'b0000);
    drive_raw(3, 7'b1111111, 1'b0);
    step(DWELL);
    scan(2, 3, 1'b0);
    scan(1, 7, 1'b0);
    drive_raw(0, 7'b0101010, 1'b0);
    step(DWELL);
    drain("t4_illegal");
    check("t4_seg_err", seg_err_cnt, 1);

    an   = 4'b0011;
    sseg = enc(5);
    dp   = 1'b1;
    step(20);
    check("t4_multi_an_frames", frame_cnt, exp_frames);
    check("t4_multi_an_seg_err", seg_err_cnt, 1);
    check("t4_hold", {d3, d2, d1, d0, dp_map}, 20'hB37E0);

    // Reset after three captures discards the partial frame.
    scan(3, 2, 1'b0);
    scan(2, 4, 1'b1);
    scan(1, 6, 1'b0);
    clr_n = 1'b0;
    #1;
    check("t5_async_digits", {d3, d2, d1, d0, dp_map}, 20'h0);
    check("t5_async_valid", frame_valid, 1'b0);
    an   = 4'hF;
    sseg = 7'h7F;
    dp   = 1'b1;
    step(3);
    clr_n = 1'b1;
    step(2);
    scan(0, 3, 1'b1);
    check("t5_partial_frames", frame_cnt, exp_frames);
    check("t5_partial_digits", {d3, d2, d1, d0, dp_map}, 20'h0);
    expect_frame(4'h8, 4'h7, 4'h1, 4'h3, 4'b0001);
    scan(3, 8, 1'b0);
    scan(2, 7, 1'b0);
    scan(1, 1, 1'b0);
    drain("t5_after_reset");
    check("t5_frames", frame_cnt, exp_frames);

    // Stale timing counted from reset release with a blank bus.
    an    = 4'hF;
    sseg  = 7'h7F;
    dp    = 1'b1;
    clr_n = 1'b0;
    step(2);
    clr_n = 1'b1;
    step(STALE - 1);
    check("t6_stale_early", stale, 1'b0);
    step(1);
    check("t6_stale_on", stale, 1'b1);
    step(5);
    check("t6_stale_held", stale, 1'b1);
    drive_raw(0, enc(5), 1'b0);
    step(5);
    check("t6_stale_pre_capture", stale, 1'b1);
    step(11);
    check("t6_stale_cleared", stale, 1'b0);
    check("t6_no_frame", frame_cnt, exp_frames);
    check("final_seg_err", seg_err_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
